reg_bank_wb: RTL and testbench
==============================

// Module: reg_bank_wb
// PURPOSE
//  Register bank on the receiving end of the write-back path: consumes the
//  32-bit word chosen by the MEMtoReg selector and supplies operands A/B.
//  After reset it runs a sweep that clears every register, then loads the
//  stack pointer with its initial value. Reads have one-cycle latency with
//  write-to-read bypass.
// PARAMETERS
//  DATA_W   32   register width
//  ADDR_W   5    register index width (2**ADDR_W registers)
//  SP_REG   29   index of stack pointer register
//  SP_INIT  227  value loaded into SP_REG by the init sweep
// PORTS
//  clk           in   1       single clock, all state on rising edge
//  reset         in   1       synchronous, active-high
//  reg_write     in   1       write enable for write-back port
//  write_reg     in   ADDR_W  destination register index
//  write_data    in   DATA_W  write-back word (MEMtoReg mux output)
//  read_reg1     in   ADDR_W  source index, port 1
//  read_reg2     in   ADDR_W  source index, port 2
//  read_data1    out  DATA_W  registered operand, port 1
//  read_data2    out  DATA_W  registered operand, port 2
//  busy          out  1       init sweep in progress
//  write_dropped out  1       1-cycle pulse: write ignored because busy
// BEHAVIOUR
//  States: INIT, RUN. A sample with reset=1 forces INIT, sweep counter
//   cnt=0, read_data1/2=0, write_dropped=0, busy=1; register contents are not
//   touched on that edge.
//  INIT: each cycle with reset=0 writes reg[cnt] <= (cnt==SP_REG) ? SP_INIT : 0,
//   then cnt++. The edge that writes cnt=2**ADDR_W-1 moves to RUN, so
//   2**ADDR_W cycles after reset falls. busy=1 for the whole of INIT and 0 in RUN.
//  reset reasserted mid-sweep: counter returns to 0 and the sweep restarts
//   from reg 0. No partial result survives.
//  INIT: reg_write is ignored and write_dropped=1 on the next cycle for each
//   ignored request. read_data1/2 are held at 0.
//  RUN write: if reg_write and write_reg!=0, reg[write_reg] <= write_data at
//   the edge. Writes to reg 0 are discarded silently, with no write_dropped pulse.
//  Reg 0 always reads 0, including when it is the target of a bypass.
//  RUN read: at each edge, read_dataN <= value of reg[read_regN]:
//   - read_regN==0 -> 0
//   - reg_write && write_reg==read_regN && read_regN!=0 -> write_data
//     (new value forwarded in the same edge)
//   - otherwise the stored value.
//   Latency: the index applied in cycle t appears on read_dataN after edge t+1.
//  Both ports are independent and may address the same register.
//  The cycle that leaves INIT samples reads as in RUN. Registers already
//   swept return 0 or SP_INIT.
//  No arithmetic: widths are pass-through only. cnt is ADDR_W+1 bits so it
//   does not wrap before the terminal compare.
// TESTING
//  1. reset 1 cycle, then idle -> busy=1 for 32 cycles, then 0. Read r29 -> 227;
//     read r1..r31 (except r29) -> 0.
//  2. After init, write r5=0xDEADBEEF, then read r5 on port1 next cycle
//     -> read_data1=0xDEADBEEF.
//  3. Same cycle: write r7=0x12345678 and read_reg2=7 -> read_data2=0x12345678
//     after that edge (bypass).
//  4. write r0=0xFFFFFFFF, then read r0 on both ports -> 0, write_dropped=0.
//  5. reg_write to r3 at sweep cycle 10 -> write_dropped pulse. After init,
//     r3 reads 0.
//  6. Write r29=0x100 after init. Reassert reset at sweep cycle 20 of a
//     new sweep -> busy for 32 more cycles, then r29=227 and r5=0.

Source files
------------

// File: rtl/reg_bank_wb.sv
// Write-back register bank: two registered read ports with same-edge
// write-to-read forwarding, one write port fed by the MEMtoReg selector,
// and a post-reset sweep that clears every register and seeds the stack
// pointer.
//
// Port 1/2 handshake: there is no valid/ready pair here. A read index applied
// in cycle t is always accepted and its operand appears after edge t+1. A
// write with reg_write=1 is always accepted in RUN. It is refused, and
// reported by write_dropped on the next cycle, while busy=1.
module reg_bank_wb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int SP_REG  = 29,
  parameter int SP_INIT = 227
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              busy,
  output logic              write_dropped
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(NREG - 1);
  localparam logic [ADDR_W:0]   CNT_SP   = (ADDR_W+1)'(SP_REG);
  localparam logic [DATA_W-1:0] SP_VAL   = DATA_W'(SP_INIT);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t state_q, state_d;

  // The counter is one bit wider than an index, so it does not wrap before
  // the terminal compare.
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic              drop_q, drop_d;

  // Effective write for this edge: either the sweep write or the write-back port.
  logic              eff_we;
  logic [ADDR_W-1:0] eff_wa;
  logic [DATA_W-1:0] eff_wd;
  logic              sweep_last;
  logic              sample_reads;
  logic [DATA_W-1:0] fwd1, fwd2;

  // FSM state register, plus sweep counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      drop_q  <= drop_d;
    end
  end

  // FSM next state: leave INIT on the edge that sweeps the last register.
  always_comb begin
    state_d    = state_q;
    sweep_last = (state_q == ST_INIT) && (cnt_q == CNT_LAST);
    case (state_q)
      ST_INIT: if (sweep_last) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // FSM outputs: busy for all of INIT; reads are sampled in RUN and on the
  // final sweep edge.
  always_comb begin
    busy         = (state_q == ST_INIT);
    sample_reads = (state_q == ST_RUN) || sweep_last;
  end

  // Select the write that happens at this edge and advance the sweep counter.
  always_comb begin
    cnt_d = cnt_q;
    if (busy) begin
      eff_we = 1'b1;
      eff_wa = cnt_q[ADDR_W-1:0];
      eff_wd = (cnt_q == CNT_SP) ? SP_VAL : '0;
      cnt_d  = cnt_q + 1'b1;
    end else begin
      eff_we = reg_write && (write_reg != '0);
      eff_wa = write_reg;
      eff_wd = write_data;
    end
    drop_d = busy && reg_write;
  end

  // Next register file contents.
  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (eff_we) regs_d[eff_wa] = eff_wd;
  end

  // Read ports: reg 0 is hard zero, and a same-edge write is forwarded.
  always_comb begin
    if (read_reg1 == '0)                     fwd1 = '0;
    else if (eff_we && eff_wa == read_reg1)  fwd1 = eff_wd;
    else                                     fwd1 = regs_q[read_reg1];

    if (read_reg2 == '0)                     fwd2 = '0;
    else if (eff_we && eff_wa == read_reg2)  fwd2 = eff_wd;
    else                                     fwd2 = regs_q[read_reg2];

    rd1_d = sample_reads ? fwd1 : '0;
    rd2_d = sample_reads ? fwd2 : '0;
  end

  // Register storage: a reset edge leaves the contents untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign read_data1    = rd1_q;
  assign read_data2    = rd2_q;
  assign write_dropped = drop_q;

endmodule

// File: tb/tb_reg_bank_wb.sv
// Bench for reg_bank_wb: init sweep timing, dropped writes during the sweep,
// a table of RUN-mode read/write vectors, and reset mid-sweep.
module tb_reg_bank_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1, read_reg2;
  logic [31:0] read_data1, read_data2;
  logic        busy, write_dropped;

  int pass_cnt = 0;
  int total    = 0;

  reg_bank_wb dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2), .busy(busy),
    .write_dropped(write_dropped)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ed;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Run a sweep from the current (reset-released) point and return its length.
  task automatic run_sweep(output int cycles, input int drop_at);
    cycles = 0;
    while (busy && cycles < 100) begin
      reg_write  = (cycles == drop_at);
      write_reg  = 5'd3;
      write_data = 32'hCAFE0003;
      step();
      cycles++;
      chk("sweep_drop", {31'd0, write_dropped}, {31'd0, cycles == drop_at + 1});
      if (busy) chk("sweep_rd1_zero", read_data1, 32'd0);
    end
    reg_write = 1'b0;
  endtask

  initial begin
    int cycles;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd29, 32'hDEADBEEF, 32'd227,      1'b0};
    vecs[2] = '{1'b1, 5'd7,  32'h12345678, 5'd5,  5'd7,  32'hDEADBEEF, 32'h12345678, 1'b0};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
    vecs[5] = '{1'b1, 5'd5,  32'hA5A5A5A5, 5'd5,  5'd5,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h12345678, 32'hA5A5A5A5, 1'b0};
    vecs[7] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd30, 32'h80000001, 32'h0,        1'b0};
    vecs[8] = '{1'b1, 5'd29, 32'h00000100, 5'd29, 5'd3,  32'h00000100, 32'h0,        1'b0};
    vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd29, 5'd31, 32'h00000100, 32'h80000001, 1'b0};

    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = 5'd29; read_reg2 = 5'd0;
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rd1", read_data1, 32'd0);
    chk("rst_rd2", read_data2, 32'd0);
    chk("rst_drop", {31'd0, write_dropped}, 32'd0);

    // Sweep with a refused write at sweep cycle 10; r29 read on the exit edge.
    reset = 1'b0;
    run_sweep(cycles, 10);
    chk("sweep_len", cycles, 32);
    chk("exit_edge_rd1_sp", read_data1, 32'd227);

    // Every register after init.
    for (int i = 1; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(i);
      step();
      chk("init_rd1", read_data1, (i == 29) ? 32'd227 : 32'd0);
      chk("init_rd2", read_data2, (i == 29) ? 32'd227 : 32'd0);
    end

    // Table-driven RUN vectors.
    for (int v = 0; v < 10; v++) begin
      reg_write  = vecs[v].we;
      write_reg  = vecs[v].wa;
      write_data = vecs[v].wd;
      read_reg1  = vecs[v].r1;
      read_reg2  = vecs[v].r2;
      step();
      chk($sformatf("vec%0d_rd1", v), read_data1, vecs[v].e1);
      chk($sformatf("vec%0d_rd2", v), read_data2, vecs[v].e2);
      chk($sformatf("vec%0d_drop", v), {31'd0, write_dropped}, {31'd0, vecs[v].ed});
      chk($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
    end
    reg_write = 1'b0;

    // Reset, run 20 sweep cycles, reset again: the full sweep restarts.
    read_reg1 = 5'd29; read_reg2 = 5'd5;
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("partial_busy", {31'd0, busy}, 32'd1);
    end
    reset = 1'b1; step(); reset = 1'b0;
    chk("rereset_busy", {31'd0, busy}, 32'd1);
    run_sweep(cycles, 1000);
    chk("resweep_len", cycles, 32);
    step();
    chk("resweep_r29", read_data1, 32'd227);
    chk("resweep_r5", read_data2, 32'd0);
    read_reg1 = 5'd31; read_reg2 = 5'd7;
    step();
    chk("resweep_r31", read_data1, 32'd0);
    chk("resweep_r7", read_data2, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
